// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header inserter/stripper pair.
package axi_stream_hdr_pkg;

    localparam int unsigned HDR_MAX_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_BODY  = 2'd2,
        ST_FLUSH = 2'd3
    } hdr_state_e;

    // Number of set bits in a (zero-extended) keep vector.
    function automatic int unsigned keep_to_cnt(input logic [HDR_MAX_BYTES-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < HDR_MAX_BYTES; i++) begin
            cnt += 32'(keep[i]);
        end
        return cnt;
    endfunction

    // Keep with the top cnt bits of a width-bit vector set.
    function automatic logic [HDR_MAX_BYTES-1:0] cnt_to_msb_keep(input int unsigned cnt,
                                                                 input int unsigned width);
        logic [HDR_MAX_BYTES-1:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < HDR_MAX_BYTES; i++) begin
            if ((i < width) && (i + cnt >= width)) begin
                keep[i] = 1'b1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axi_stream_realign.sv
// Combinational byte combiner: appends the top s bytes of a beat to an MSB-aligned residual.
module axi_stream_realign
    import axi_stream_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      residual,
    input  logic [DATA_WD-1:0]      beat,
    input  logic [BYTE_CNT_WD-1:0]  s,
    input  logic [BYTE_CNT_WD:0]    beat_cnt,
    output logic [DATA_WD-1:0]      data_c,
    output logic [DATA_BYTE_WD-1:0] keep_c,
    output logic                    overflow_c
);

    int unsigned total;

    // s == 0 means the stream is already aligned; otherwise residual fills the top W-s bytes.
    always_comb begin
        total      = 32'(beat_cnt);
        data_c     = beat;
        keep_c     = DATA_BYTE_WD'(cnt_to_msb_keep(32'(beat_cnt), DATA_BYTE_WD));
        overflow_c = 1'b0;
        if (s != '0) begin
            total  = DATA_BYTE_WD - 32'(s) + 32'(beat_cnt);
            data_c = residual | (beat >> (8 * (DATA_BYTE_WD - 32'(s))));
            if (total > DATA_BYTE_WD) begin
                keep_c     = '1;
                overflow_c = 1'b1;
            end else begin
                keep_c = DATA_BYTE_WD'(cnt_to_msb_keep(total, DATA_BYTE_WD));
            end
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte header from an AXI-Stream packet and re-aligns the payload MSB-first.
// Optional runt counter port err_cnt when STRIP_HEADER_ERR_CNT_EN is defined.
module axi_stream_strip_header
    import axi_stream_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
    output logic                    ready_strip,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
`ifdef STRIP_HEADER_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt
`endif
);

    localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;

    hdr_state_e               state_q, state_d;
    logic [CNT_WD-1:0]        n_q;
    logic [BYTE_CNT_WD-1:0]   s_q;
    logic [CNT_WD-1:0]        flush_cnt_q, flush_cnt_d;
    logic [DATA_WD-1:0]       resid_q;

    logic [CNT_WD-1:0]        strip_n;
    logic [BYTE_CNT_WD-1:0]   strip_s;
    logic [CNT_WD-1:0]        in_cnt;
    logic [CNT_WD-1:0]        hn;
    logic [DATA_WD-1:0]       beat_m;
    logic [DATA_WD-1:0]       hdr_data;
    logic [DATA_BYTE_WD-1:0]  hdr_keep;
    logic                     in_fire, strip_fire, out_free;

    logic                     cnt_load, hdr_load, resid_load, out_load;
    logic [DATA_WD-1:0]       out_data_d;
    logic [DATA_BYTE_WD-1:0]  out_keep_d;
    logic                     out_last_d;

    logic [DATA_WD-1:0]       rl_data;
    logic [DATA_BYTE_WD-1:0]  rl_keep;
    logic                     rl_overflow;

    assign out_free    = !valid_out || ready_out;
    assign ready_strip = (state_q == ST_IDLE) && !valid_header;
    assign ready_in    = ((state_q == ST_HEAD) || (state_q == ST_BODY)) && out_free;
    assign in_fire     = valid_in && ready_in;
    assign strip_fire  = valid_strip && ready_strip;

    assign strip_n = CNT_WD'(strip_cnt) + CNT_WD'(1);
    assign strip_s = (32'(strip_n) == DATA_BYTE_WD) ? '0 : BYTE_CNT_WD'(strip_n);
    assign in_cnt  = CNT_WD'(keep_to_cnt(HDR_MAX_BYTES'(keep_in)));

    // Bytes outside keep are forced to zero so residual/flush beats carry clean padding.
    always_comb begin
        beat_m = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            if (keep_in[i]) begin
                beat_m[i*8 +: 8] = data_in[i*8 +: 8];
            end
        end
    end

    // A runt shorter than N yields only its c bytes as header.
    assign hn       = (last_in && (in_cnt < n_q)) ? in_cnt : n_q;
    assign hdr_data = beat_m >> (8 * (DATA_BYTE_WD - 32'(hn)));

    always_comb begin
        hdr_keep = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            hdr_keep[i] = (i < 32'(hn));
        end
    end

    axi_stream_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .residual   (resid_q),
        .beat       (beat_m),
        .s          (s_q),
        .beat_cnt   (in_cnt),
        .data_c     (rl_data),
        .keep_c     (rl_keep),
        .overflow_c (rl_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        hdr_load    = 1'b0;
        resid_load  = 1'b0;
        out_load    = 1'b0;
        out_data_d  = '0;
        out_keep_d  = '0;
        out_last_d  = 1'b0;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strip_fire) begin
                    cnt_load = 1'b1;
                    state_d  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (in_fire) begin
                    hdr_load   = 1'b1;
                    resid_load = 1'b1;
                    if (!last_in) begin
                        state_d = ST_BODY;
                    end else if (in_cnt > n_q) begin
                        // Single-beat packet longer than the header: leftover goes out via FLUSH.
                        flush_cnt_d = in_cnt - n_q;
                        state_d     = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BODY: begin
                if (in_fire) begin
                    out_load   = 1'b1;
                    resid_load = 1'b1;
                    out_data_d = rl_data;
                    out_keep_d = rl_keep;
                    if (last_in) begin
                        if (rl_overflow) begin
                            flush_cnt_d = in_cnt - CNT_WD'(s_q);
                            state_d     = ST_FLUSH;
                        end else begin
                            out_last_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    out_load   = 1'b1;
                    out_data_d = resid_q;
                    out_keep_d = DATA_BYTE_WD'(cnt_to_msb_keep(32'(flush_cnt_q), DATA_BYTE_WD));
                    out_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet context and residual bytes (kept MSB-aligned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= '0;
            s_q         <= '0;
            flush_cnt_q <= '0;
            resid_q     <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            if (cnt_load) begin
                n_q <= strip_n;
                s_q <= strip_s;
            end
            if (resid_load) begin
                resid_q <= beat_m << (8 * 32'(s_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (out_load) begin
            valid_out <= 1'b1;
            data_out  <= out_data_d;
            keep_out  <= out_keep_d;
            last_out  <= out_last_d;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else if (hdr_load) begin
            valid_header <= 1'b1;
            data_header  <= hdr_data;
            keep_header  <= hdr_keep;
        end else if (ready_header) begin
            valid_header <= 1'b0;
        end
    end

`ifdef STRIP_HEADER_ERR_CNT_EN
    logic runt;

    assign runt = (state_q == ST_HEAD) && in_fire && last_in && (in_cnt <= n_q);

    // Saturating runt counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (runt && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: byte-level reference model, random traffic and stalls.
module tb_axi_stream_strip_header;

    localparam int unsigned DATA_WD = 32;
    localparam int unsigned W       = 4;
    localparam int unsigned CW      = 2;
    localparam int          TO      = 500;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_strip, ready_strip;
    logic [CW-1:0] strip_cnt;
    logic          valid_in, last_in, ready_in;
    logic [31:0]   data_in;
    logic [3:0]    keep_in;
    logic          valid_header, ready_header;
    logic [31:0]   data_header;
    logic [3:0]    keep_header;
    logic          valid_out, last_out, ready_out;
    logic [31:0]   data_out;
    logic [3:0]    keep_out;
`ifdef STRIP_HEADER_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    beat_t exp_pay[$];
    beat_t exp_hdr[$];
    int    total = 0;
    int    bad = 0;
    int    runts = 0;
    bit    mon_en = 1'b0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_strip  (valid_strip),
        .strip_cnt    (strip_cnt),
        .ready_strip  (ready_strip),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_header (valid_header),
        .data_header  (data_header),
        .keep_header  (keep_header),
        .ready_header (ready_header),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out)
`ifdef STRIP_HEADER_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endfunction

    function automatic byte_q_t mk(input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input int len);
        logic [95:0] all;
        byte_q_t     q;
        all = {w0, w1, w2};
        for (int i = 0; i < len; i++) q.push_back(all[95-8*i -: 8]);
        return q;
    endfunction

    // Reference: header = first min(N,len) bytes right-aligned; payload = rest, packed MSB-first.
    task automatic model_push(input int n, input byte_q_t b);
        int    len;
        int    h;
        beat_t e;
        len = b.size();
        h   = (len < n) ? len : n;
        e   = '0;
        for (int i = 0; i < h; i++) begin
            e.data = {e.data[23:0], b[i]};
            e.keep = {e.keep[2:0], 1'b1};
        end
        exp_hdr.push_back(e);
        if (len <= n) runts++;
        for (int p = n; p < len; p += W) begin
            e = '0;
            for (int j = 0; j < W; j++) begin
                e.data = e.data << 8;
                e.keep = e.keep << 1;
                if (p + j < len) begin
                    e.data[7:0] = b[p+j];
                    e.keep[0]   = 1'b1;
                end
            end
            e.last = (p + W >= len);
            exp_pay.push_back(e);
        end
    endtask

    task automatic send_packet(input int n, input byte_q_t b, input int max_beats,
                               input bit push, input bit gaps);
        int len;
        int nb;
        int cyc;
        len = b.size();
        nb  = (len + W - 1) / W;
        if (push) model_push(n, b);
        valid_strip = 1'b1;
        strip_cnt   = CW'(n - 1);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (ready_strip) break;
            if (++cyc > TO) begin
                timeout("strip handshake");
                valid_strip = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        valid_strip = 1'b0;
        for (int k = 0; k < nb && k < max_beats; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            data_in = '0;
            keep_in = '0;
            for (int j = 0; j < W; j++) begin
                data_in = data_in << 8;
                keep_in = keep_in << 1;
                if (k * W + j < len) begin
                    data_in[7:0] = b[k*W+j];
                    keep_in[0]   = 1'b1;
                end
            end
            valid_in = 1'b1;
            last_in  = (k == nb - 1);
            cyc = 0;
            forever begin
                @(negedge clk);
                if (ready_in) break;
                if (++cyc > TO) begin
                    timeout("input beat");
                    valid_in = 1'b0;
                    last_in  = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            valid_in = 1'b0;
            last_in  = 1'b0;
            data_in  = '0;
            keep_in  = '0;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
            @(negedge clk);
            if (++cyc > 3000) begin
                timeout("output drain");
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " valid_out"},    32'(valid_out), 0);
        chk({tag, " valid_header"}, 32'(valid_header), 0);
        chk({tag, " last_out"},     32'(last_out), 0);
        chk({tag, " data_out"},     data_out, 0);
        chk({tag, " keep_out"},     32'(keep_out), 0);
        chk({tag, " data_header"},  data_header, 0);
        chk({tag, " keep_header"},  32'(keep_header), 0);
        chk({tag, " ready_strip"},  32'(ready_strip), 1);
        chk({tag, " ready_in"},     32'(ready_in), 0);
`ifdef STRIP_HEADER_ERR_CNT_EN
        chk({tag, " err_cnt"},      32'(err_cnt), 0);
`endif
    endtask

    // Sink ready generation: always ready, random, or a fixed stall schedule.
    initial begin
        int sched_cyc;
        int prev_mode;
        sched_cyc    = 0;
        prev_mode    = 0;
        ready_out    = 1'b1;
        ready_header = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 2 && prev_mode != 2) sched_cyc = 0;
            prev_mode = rdy_mode;
            case (rdy_mode)
                0: begin
                    ready_out    = 1'b1;
                    ready_header = 1'b1;
                end
                1: begin
                    ready_out    = ($urandom_range(0, 3) != 0);
                    ready_header = ($urandom_range(0, 2) != 0);
                end
                default: begin
                    ready_out    = !(sched_cyc >= 3 && sched_cyc <= 5);
                    ready_header = !(sched_cyc >= 2 && sched_cyc <= 5);
                    sched_cyc++;
                end
            endcase
        end
    end

    // Monitor: compare presented beats with the queue head, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (valid_out) begin
                if (exp_pay.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL payload unexpected: got %h/%b last=%b", data_out, keep_out, last_out);
                end else begin
                    chk("payload data", data_out, exp_pay[0].data);
                    chk("payload keep", 32'(keep_out), 32'(exp_pay[0].keep));
                    chk("payload last", 32'(last_out), 32'(exp_pay[0].last));
                    if (ready_out) void'(exp_pay.pop_front());
                end
                if (!ready_out) chk("ready_in during output stall", 32'(ready_in), 0);
            end
            if (valid_header) begin
                if (exp_hdr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL header unexpected: got %h/%b", data_header, keep_header);
                end else begin
                    chk("header data", data_header, exp_hdr[0].data);
                    chk("header keep", 32'(keep_header), 32'(exp_hdr[0].keep));
                    if (ready_header) void'(exp_hdr.pop_front());
                end
                chk("ready_strip while header pending", 32'(ready_strip), 0);
            end
        end
    end

    initial begin
        byte_q_t s1, s2, s3, s4, rb;
        int      n, len;
        valid_strip = 1'b0;
        strip_cnt   = '0;
        valid_in    = 1'b0;
        data_in     = '0;
        keep_in     = '0;
        last_in     = 1'b0;

        s1 = mk(32'hAABBCCDD, 32'h11223344, 32'h55667700, 11);
        s2 = mk(32'hAABBCCDD, 32'h11223344, 32'h55660000, 10);
        s3 = mk(32'hAABBCCDD, 32'h11223344, 32'h00000000, 6);
        s4 = mk(32'hAABBCCDD, 32'h00000000, 32'h00000000, 2);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("after reset");
        mon_en = 1'b1;

        // Directed cases with an always-ready sink.
        send_packet(2, s1, 100, 1'b1, 1'b0);
        send_packet(4, s2, 100, 1'b1, 1'b0);
        send_packet(3, s3, 100, 1'b1, 1'b0);
        send_packet(3, s4, 100, 1'b1, 1'b0);
        wait_drain();

        // Stall schedule on both sinks, then an immediate follow-on packet.
        rdy_mode = 2;
        send_packet(2, s1, 100, 1'b1, 1'b0);
        send_packet(3, s3, 100, 1'b1, 1'b0);
        wait_drain();

        // Random packets with random source gaps and sink backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 200; p++) begin
            n   = $urandom_range(1, W);
            len = $urandom_range(1, 18);
            rb.delete();
            for (int i = 0; i < len; i++) rb.push_back(8'($urandom_range(0, 255)));
            send_packet(n, rb, 100, 1'b1, 1'b1);
        end
        rdy_mode = 0;
        wait_drain();
`ifdef STRIP_HEADER_ERR_CNT_EN
        chk("err_cnt before abort", 32'(err_cnt), 32'(runts));
`endif

        // Abort mid-packet: two beats of scenario 1 leave the block in BODY.
        mon_en = 1'b0;
        send_packet(2, s1, 2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_vals("mid-packet reset");
        exp_pay.delete();
        exp_hdr.delete();
        runts = 0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("after abort");
        mon_en = 1'b1;
        send_packet(3, s3, 100, 1'b1, 1'b0);
        wait_drain();
`ifdef STRIP_HEADER_ERR_CNT_EN
        chk("err_cnt after abort", 32'(err_cnt), 32'(runts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
